fxp_accumulate_seq: RTL



---
 rtl/fxp_pkg.sv | 35 +++
 rtl/fxp_sat_clamp.sv | 41 ++++
 rtl/fxp_accumulate_seq.sv | 127 ++++++++++++
 3 files changed

// File: rtl/fxp_pkg.sv
// rtl/fxp_pkg.sv - shared fixed-point types, saturation constants and overflow helper
//
// Purpose: common definitions for the fixed-point arithmetic units.
//   state_t      : accumulator controller states (IDLE, ACCUM, HOLD)
//   fxp_max(n)   : largest signed n-bit value, returned in FXP_MAX_W bits
//   fxp_min(n)   : smallest signed n-bit value, returned in FXP_MAX_W bits
//   fxp_add_ovf  : signed add overflow from the operand and sum sign bits
// Ports: none (package).
package fxp_pkg;

  // Widest datapath the saturation helpers support; callers cast down to N.
  localparam int FXP_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

  function automatic logic [FXP_MAX_W-1:0] fxp_max(input int n);
    return (FXP_MAX_W'(1) << (n - 1)) - FXP_MAX_W'(1);
  endfunction

  // Only the low n bits are meaningful: 1 followed by n-1 zeros.
  function automatic logic [FXP_MAX_W-1:0] fxp_min(input int n);
    return FXP_MAX_W'(1) << (n - 1);
  endfunction

  // Overflow when both operands share a sign and the sum's sign differs.
  function automatic logic fxp_add_ovf(input logic a_msb, input logic b_msb,
                                       input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/fxp_sat_clamp.sv
// rtl/fxp_sat_clamp.sv - signed overflow detect and optional clamp of the adder sum
//
// Purpose: derives the next accumulator value from the external adder result.
// Optional feature macro: FXP_ACC_SATURATE_EN (defined: clamp on overflow,
// undefined: wrap modulo 2**N).
// Ports:
//   add_a    in  N  adder operand A (accumulator)
//   add_b    in  N  adder operand B (incoming operand)
//   add_s    in  N  adder sum
//   ovf      out 1  signed overflow of this add
//   next_acc out N  value to load into the accumulator
module fxp_sat_clamp
  import fxp_pkg::*;
#(
  parameter int N = 32
) (
  input  logic [N-1:0] add_a,
  input  logic [N-1:0] add_b,
  input  logic [N-1:0] add_s,
  output logic         ovf,
  output logic [N-1:0] next_acc
);

  assign ovf = fxp_add_ovf(add_a[N-1], add_b[N-1], add_s[N-1]);

`ifdef FXP_ACC_SATURATE_EN
  localparam logic [N-1:0] SAT_MAX = N'(fxp_max(N));
  localparam logic [N-1:0] SAT_MIN = N'(fxp_min(N));

  // On overflow both operands share add_a's sign, so it picks the rail.
  always_comb begin
    next_acc = add_s;
    if (ovf) begin
      next_acc = add_a[N-1] ? SAT_MIN : SAT_MAX;
    end
  end
`else
  assign next_acc = add_s;
`endif

endmodule

// File: rtl/fxp_accumulate_seq.sv
// rtl/fxp_accumulate_seq.sv - sequential accumulator around an external N-bit adder
//
// Purpose: sums a run of len signed operands using the team's combinational
// adder and returns one total with sticky overflow and carry flags.
// Optional feature macro: FXP_ACC_SATURATE_EN (saturating accumulate).
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   start, len          begin a run of len operands (sampled in IDLE only)
//   in_valid/in_ready   operand stream handshake, in_data operand
//   add_a/add_b/add_ci  adder operands (acc, in_data, 0)
//   add_s/add_co        adder sum and carry-out
//   out_valid/out_ready result handshake
//   out_sum/out_ovf/out_carry result total and sticky flags
//   busy                high in ACCUM and HOLD
module fxp_accumulate_seq
  import fxp_pkg::*;
#(
  parameter int N       = 32,
  parameter int COUNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [COUNT_W-1:0] len,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N-1:0]       in_data,
  output logic [N-1:0]       add_a,
  output logic [N-1:0]       add_b,
  output logic               add_ci,
  input  logic [N-1:0]       add_s,
  input  logic               add_co,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N-1:0]       out_sum,
  output logic               out_ovf,
  output logic               out_carry,
  output logic               busy
);

  state_t             state, state_nxt;
  logic [N-1:0]       acc;
  logic [COUNT_W-1:0] remaining;
  logic               ovf_r;
  logic               carry_r;
  logic               beat;
  logic               beat_ovf;
  logic [N-1:0]       next_acc;

  assign add_a  = acc;
  assign add_b  = in_data;
  assign add_ci = 1'b0;

  assign beat = in_valid && in_ready;

  fxp_sat_clamp #(.N(N)) u_clamp (
    .add_a    (add_a),
    .add_b    (add_b),
    .add_s    (add_s),
    .ovf      (beat_ovf),
    .next_acc (next_acc)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; a zero-length run goes straight to HOLD with a zero total.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (len != '0) ? ACCUM : HOLD;
      ACCUM:   if (beat && remaining == COUNT_W'(1)) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        busy     = 1'b1;
      end
      HOLD: begin
        out_valid = 1'b1;
        busy      = 1'b1;
      end
      default: ;
    endcase
  end

  // Accumulator, beat counter and sticky flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc       <= '0;
      remaining <= '0;
      ovf_r     <= 1'b0;
      carry_r   <= 1'b0;
    end else if (state == IDLE && start) begin
      acc       <= '0;
      remaining <= len;
      ovf_r     <= 1'b0;
      carry_r   <= 1'b0;
    end else if (beat) begin
      acc       <= next_acc;
      remaining <= remaining - COUNT_W'(1);
      ovf_r     <= ovf_r | beat_ovf;
      carry_r   <= carry_r | add_co;
    end
  end

  // Registers only change in IDLE/ACCUM, so the result is stable through HOLD.
  assign out_sum   = acc;
  assign out_ovf   = ovf_r;
  assign out_carry = carry_r;

endmodule
